// File: rtl/player_input_ctrl.sv
`default_nettype none
//==============================================================================
//  Module      : player_input_ctrl
//  Description : Synchronises and debounces four player buttons, arbitrates
//                the first press into a latched playerInputFlag, and releases
//                the flag on a software store of an even value to ACK_ADDR.
//  Revision    : 1.0 - initial release
//==============================================================================
module player_input_ctrl #(
    parameter int               WIDTH    = 16,
    parameter int               DEBOUNCE = 4,
    parameter logic [WIDTH-1:0] ACK_ADDR = 16'd37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic             playerInputFlag,
    output logic [1:0]       winner,
    output logic [3:0]       btn_state,
    output logic [3:0]       ignored_cnt
);

    // Counter only has to reach DEBOUNCE-1, so clog2(DEBOUNCE) bits suffice.
    localparam int                c_CNT_W    = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE - 1);
    localparam logic [3:0]        c_IGN_MAX  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_LOCKED       = 2'd1,
        ST_RELEASE_WAIT = 2'd2
    } state_t;

    logic [3:0] r_sync1;
    logic [3:0] r_sync2;
    logic [3:0] r_btn_state;
    logic [3:0] r_btn_state_d;
    logic [3:0] w_accept;
    logic [3:0] w_press;
    logic       w_any_press;
    logic [1:0] w_first_idx;
    logic       w_ack;
    logic       w_unused_wdata;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_flag;
    logic       w_flag_nxt;
    logic [1:0] r_winner;
    logic [1:0] w_winner_nxt;
    logic [3:0] r_ignored;
    logic [3:0] w_ignored_nxt;

    // Two-flop synchroniser for the asynchronous button pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'b0;
            r_sync2 <= 4'b0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debounce: count consecutive samples that disagree with the
    // accepted level; accept on the DEBOUNCE-th one.
    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_diff;
        logic               w_hit;

        assign w_diff      = r_sync2[i] ^ r_btn_state[i];
        assign w_hit       = w_diff && (r_cnt == c_CNT_LAST);
        assign w_accept[i] = w_hit;

        // Counter clears on agreement or on acceptance, otherwise advances.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (!w_diff || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    // Accepted level flips when its debounce window completes; keep a delayed
    // copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_btn_state   <= 4'b0;
            r_btn_state_d <= 4'b0;
        end else begin
            r_btn_state   <= r_btn_state ^ w_accept;
            r_btn_state_d <= r_btn_state;
        end
    end

    assign w_press     = r_btn_state & ~r_btn_state_d;
    assign w_any_press = |w_press;

    // Lowest index wins when several presses land in the same cycle.
    always_comb begin
        w_first_idx = 2'd0;
        if (w_press[0]) begin
            w_first_idx = 2'd0;
        end else if (w_press[1]) begin
            w_first_idx = 2'd1;
        end else if (w_press[2]) begin
            w_first_idx = 2'd2;
        end else if (w_press[3]) begin
            w_first_idx = 2'd3;
        end
    end

    // Only bit 0 of the store data selects ack; the rest is don't-care.
    assign w_ack          = memwrite && (adr == ACK_ADDR) && !writedata[0];
    assign w_unused_wdata = ^writedata[WIDTH-1:1];

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_flag    <= 1'b0;
            r_winner  <= 2'd0;
            r_ignored <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_flag    <= w_flag_nxt;
            r_winner  <= w_winner_nxt;
            r_ignored <= w_ignored_nxt;
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_flag_nxt    = r_flag;
        w_winner_nxt  = r_winner;
        w_ignored_nxt = r_ignored;
        case (r_state)
            ST_IDLE: begin
                // An ack here has nothing to release and is dropped.
                w_flag_nxt = 1'b0;
                if (w_any_press) begin
                    w_winner_nxt  = w_first_idx;
                    w_flag_nxt    = 1'b1;
                    w_ignored_nxt = 4'd0;
                    w_state_nxt   = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                w_flag_nxt = 1'b1;
                // A press in the ack cycle is still counted.
                if (w_any_press && (r_ignored != c_IGN_MAX)) begin
                    w_ignored_nxt = r_ignored + 4'd1;
                end
                if (w_ack) begin
                    w_flag_nxt  = 1'b0;
                    w_state_nxt = ST_RELEASE_WAIT;
                end
            end
            ST_RELEASE_WAIT: begin
                // Wait for every button to be released so a held button
                // cannot immediately re-trigger.
                w_flag_nxt = 1'b0;
                if (r_btn_state == 4'b0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_flag_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign playerInputFlag = r_flag;
    assign winner          = r_winner;
    assign btn_state       = r_btn_state;
    assign ignored_cnt     = r_ignored;

endmodule
`default_nettype wire

// File: tb/tb_player_input_ctrl.sv
`default_nettype none
//==============================================================================
//  Module      : tb_player_input_ctrl
//  Description : Scoreboard bench for player_input_ctrl. Stimulus queues
//                cycle-stamped output snapshots; a monitor compares them and
//                also flags any output change nobody predicted.
//  Revision    : 1.0 - initial release
//==============================================================================
module tb_player_input_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  btn;
    logic        memwrite;
    logic [15:0] adr;
    logic [15:0] writedata;
    logic        playerInputFlag;
    logic [1:0]  winner;
    logic [3:0]  btn_state;
    logic [3:0]  ignored_cnt;

    player_input_ctrl #(
        .WIDTH    (16),
        .DEBOUNCE (4),
        .ACK_ADDR (16'd37)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn             (btn),
        .memwrite        (memwrite),
        .adr             (adr),
        .writedata       (writedata),
        .playerInputFlag (playerInputFlag),
        .winner          (winner),
        .btn_state       (btn_state),
        .ignored_cnt     (ignored_cnt)
    );

    // Snapshot layout: {flag, winner[1:0], btn_state[3:0], ignored_cnt[3:0]}
    typedef struct {
        int          cyc;
        logic [10:0] val;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc        = 0;
    int          n_compared = 0;
    int          n_mismatch = 0;
    logic [10:0] prev_snap;
    bit          have_prev  = 0;
    int          t;
    int          ign;
    int          ign_old;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Queue an expected snapshot, kept ordered by cycle.
    function automatic void exp_at(input int c, input logic f, input logic [1:0] w,
                                   input logic [3:0] b, input logic [3:0] ig,
                                   input string n);
        exp_t e;
        int   pos;
        e.cyc  = c;
        e.val  = {f, w, b, ig};
        e.name = n;
        pos = exp_q.size();
        while (pos > 0 && exp_q[pos-1].cyc > c) pos--;
        exp_q.insert(pos, e);
    endfunction

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        logic [10:0] snap;
        exp_t        e;
        bit          due;
        if (cyc >= 1) begin
            snap = {playerInputFlag, winner, btn_state, ignored_cnt};
            due  = 0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                n_compared++;
                n_mismatch++;
                $display("FAIL %s: check for cyc %0d was never sampled (now cyc %0d)",
                         e.name, e.cyc, cyc);
            end
            while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e   = exp_q.pop_front();
                due = 1;
                n_compared++;
                if (snap !== e.val) begin
                    n_mismatch++;
                    $display("FAIL %s @cyc %0d: {flag,win,bs,ign} got %b_%b_%b_%b want %b_%b_%b_%b",
                             e.name, cyc, snap[10], snap[9:8], snap[7:4], snap[3:0],
                             e.val[10], e.val[9:8], e.val[7:4], e.val[3:0]);
                end
            end
            if (have_prev && !due && (snap !== prev_snap)) begin
                n_compared++;
                n_mismatch++;
                $display("FAIL unexpected_change @cyc %0d: {flag,win,bs,ign} got %b_%b_%b_%b want %b_%b_%b_%b",
                         cyc, snap[10], snap[9:8], snap[7:4], snap[3:0],
                         prev_snap[10], prev_snap[9:8], prev_snap[7:4], prev_snap[3:0]);
            end
            prev_snap = snap;
            have_prev = 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset held two cycles with all buttons pressed.
        rst = 1'b1; btn = 4'hF; memwrite = 1'b0; adr = 16'd0; writedata = 16'd0;
        exp_at(1, 0, 2'd0, 4'b0000, 4'd0, "reset_c1");
        exp_at(2, 0, 2'd0, 4'b0000, 4'd0, "reset_c2");
        exp_at(3, 0, 2'd0, 4'b0000, 4'd0, "reset_after");
        tick(2);
        rst = 1'b0; btn = 4'b0000;
        tick(3);

        // Bounce on btn[2] then a steady hold.
        btn = 4'b0100; tick();
        btn = 4'b0000; tick();
        btn = 4'b0100; tick();
        btn = 4'b0000; tick();
        btn = 4'b0100; t = cyc;
        exp_at(t + 6, 0, 2'd2 & 2'd0, 4'b0100, 4'd0, "bounce_bs");
        exp_at(t + 7, 1, 2'd2, 4'b0100, 4'd0, "bounce_flag");
        tick(10);

        // Lockout: presses while locked are counted, not arbitrated.
        btn = 4'b0101; t = cyc;
        exp_at(t + 6, 1, 2'd2, 4'b0101, 4'd0, "lock_bs0");
        exp_at(t + 7, 1, 2'd2, 4'b0101, 4'd1, "lock_btn0");
        tick(10);
        btn = 4'b1101; t = cyc;
        exp_at(t + 6, 1, 2'd2, 4'b1101, 4'd1, "lock_bs3");
        exp_at(t + 7, 1, 2'd2, 4'b1101, 4'd2, "lock_btn3");
        tick(10);
        ign = 2;
        for (int k = 0; k < 18; k++) begin
            btn = 4'b0101; t = cyc;
            exp_at(t + 6, 1, 2'd2, 4'b0101, 4'(ign), "lock_release");
            tick(8);
            btn = 4'b1101; t = cyc;
            ign_old = ign;
            ign = (ign == 15) ? 15 : ign + 1;
            exp_at(t + 6, 1, 2'd2, 4'b1101, 4'(ign_old), "lock_repress_bs");
            exp_at(t + 7, 1, 2'd2, 4'b1101, 4'(ign), "lock_count_sat");
            tick(8);
        end

        // Stores that must not acknowledge.
        t = cyc;
        exp_at(t + 1, 1, 2'd2, 4'b1101, 4'd15, "nonack_adr36");
        exp_at(t + 2, 1, 2'd2, 4'b1101, 4'd15, "nonack_data1");
        exp_at(t + 3, 1, 2'd2, 4'b1101, 4'd15, "nonack_adr_hi");
        exp_at(t + 4, 1, 2'd2, 4'b1101, 4'd15, "nonack_nowrite");
        memwrite = 1'b1; adr = 16'd36;    writedata = 16'h0000; tick();
        adr = 16'd37;    writedata = 16'h0001; tick();
        adr = 16'h8025;  writedata = 16'h0000; tick();
        memwrite = 1'b0; adr = 16'd37;    writedata = 16'h0000; tick();

        // Ack releases the flag; held buttons cannot re-trigger.
        memwrite = 1'b1; adr = 16'd37; writedata = 16'h0000; t = cyc;
        exp_at(t + 1, 0, 2'd2, 4'b1101, 4'd15, "ack_flag_clear");
        tick();
        memwrite = 1'b0;
        btn = 4'b1111; t = cyc;
        exp_at(t + 6, 0, 2'd2, 4'b1111, 4'd15, "rw_press_discarded");
        exp_at(t + 9, 0, 2'd2, 4'b1111, 4'd15, "rw_held_noflag");
        tick(10);
        btn = 4'b0000; t = cyc;
        exp_at(t + 6, 0, 2'd2, 4'b0000, 4'd15, "release_all");
        tick(10);
        btn = 4'b1000; t = cyc;
        exp_at(t + 6, 0, 2'd2, 4'b1000, 4'd15, "repress_bs3");
        exp_at(t + 7, 1, 2'd3, 4'b1000, 4'd0, "repress_btn3");
        tick(10);

        // Ack with only bit 0 clear, release, ack in IDLE, simultaneous press.
        memwrite = 1'b1; adr = 16'd37; writedata = 16'hFFFE; t = cyc;
        exp_at(t + 1, 0, 2'd3, 4'b1000, 4'd0, "ack_even_data");
        tick();
        memwrite = 1'b0; btn = 4'b0000; t = cyc;
        exp_at(t + 6, 0, 2'd3, 4'b0000, 4'd0, "release2");
        tick(10);
        memwrite = 1'b1; adr = 16'd37; writedata = 16'h0000; t = cyc;
        exp_at(t + 1, 0, 2'd3, 4'b0000, 4'd0, "ack_in_idle");
        exp_at(t + 2, 0, 2'd3, 4'b0000, 4'd0, "ack_in_idle_after");
        tick();
        memwrite = 1'b0;
        tick();
        btn = 4'b1010; t = cyc;
        exp_at(t + 6, 0, 2'd3, 4'b1010, 4'd0, "simul_bs");
        exp_at(t + 7, 1, 2'd1, 4'b1010, 4'd0, "simul_winner1");
        tick(10);

        // Reset while locked, button held through it.
        rst = 1'b1; t = cyc;
        exp_at(t + 1, 0, 2'd0, 4'b0000, 4'd0, "reset_locked");
        tick();
        rst = 1'b0; t = cyc;
        exp_at(t + 6, 0, 2'd0, 4'b1010, 4'd0, "held_rebounce");
        exp_at(t + 7, 1, 2'd1, 4'b1010, 4'd0, "held_reflag");
        tick(10);

        for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_compared++;
            n_mismatch++;
            $display("FAIL %s: expected check at cyc %0d never reached", e.name, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/player_input_ctrl.md
Name: player_input_ctrl

Overview:
- Conditions the four raw player buttons and arbitrates the first press.
- Produces the playerInputFlag level that the memory stage mirrors into address 37 every cycle.
- The flag latches on the first debounced press and holds until software clears it with a store to the acknowledge address.
- The winning player index and a lockout count are exported for the memory map and debug.

Parameters:
- WIDTH, 16, data/address width of the store-snoop bus.
- DEBOUNCE, 4, consecutive differing synchronized samples required to accept a button change (≥2).
- ACK_ADDR, 16'd37, store address that acknowledges or clears the flag.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn  in  4  raw asynchronous player buttons, active-high; btn[0] is player 0.
- memwrite  in  1  store strobe, snooped from the core.
- adr  in  WIDTH  store address.
- writedata  in  WIDTH  store data.
- playerInputFlag  out  1  registered flag: a press is pending.
- winner  out  2  index of the player who won arbitration.
- btn_state  out  4  debounced button levels.
- ignored_cnt  out  4  presses rejected while locked, saturating.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high; all state updates on posedge clk.
- Reset values: playerInputFlag 0, winner 0, btn_state 0, ignored_cnt 0, synchronizers 0, debounce counters 0, FSM IDLE.
- Synchronizer: a 2-flop synchronizer per button. sync[i] is btn[i] delayed 2 cycles.
- Debounce, per button:
  - If sync[i] equals btn_state[i], the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE-1 and sync[i] still differs, btn_state[i] takes sync[i] and the counter clears.
  - A change is accepted on the DEBOUNCE-th consecutive differing sample.
  - Total pin-to-btn_state latency is 2+DEBOUNCE cycles after the pin settles.
  - Any glitch shorter than DEBOUNCE samples is rejected.
- Press pulse: press[i] = btn_state[i] & ~btn_state_d[i], where btn_state_d is a one-cycle-delayed copy. The pulse is one cycle wide.
- Ack: ack = memwrite & (adr == ACK_ADDR) & (writedata[0] == 0).
- FSM IDLE:
  - If any press is asserted: winner <= lowest set index (btn0 has highest priority); playerInputFlag <= 1; ignored_cnt <= 0; go LOCKED.
  - An ack in IDLE is ignored.
  - A press and an ack in the same cycle: the press is taken.
- FSM LOCKED:
  - playerInputFlag stays 1 and winner is frozen.
  - Each cycle with any press asserted, ignored_cnt increments by 1 and saturates at 15. Multiple buttons in one cycle count as 1.
  - On ack: playerInputFlag <= 0; go RELEASE_WAIT. A press in the ack cycle is counted, then the ack takes effect.
- FSM RELEASE_WAIT:
  - playerInputFlag stays 0 and presses are discarded (not counted).
  - When btn_state == 0, go IDLE on the next edge.
  - This blocks re-triggering from a held button.
- Outputs: all outputs are registered; playerInputFlag rises 1 cycle after the press pulse.
- Reset mid-operation: returns to IDLE with the flag cleared on the next edge. A button held through reset is debounced afresh from btn_state=0 and can raise a new flag once accepted.
- Illegal FSM encoding: recovers to IDLE with flag 0.
- Store snoop: adr/writedata compare uses the full WIDTH bits. Writes to other addresses have no effect.

Test Plan:
- Reset: assert rst 2 cycles with btn=4'b1111 → playerInputFlag=0, winner=0, btn_state=0, ignored_cnt=0 during reset and the cycle after.
- Bounce rejection, DEBOUNCE=4:
  - btn[2] toggles 1,0,1,0 on successive cycles, then holds 1.
  - btn_state[2] rises exactly 6 cycles after the final rising edge.
  - No earlier btn_state change occurs.
  - playerInputFlag=1 one cycle later, winner=2.
- Simultaneous press: btn[1] and btn[3] rise on the same cycle → winner=1, flag=1.
- Lockout: with winner=2 locked, debounced presses on btn0 then btn3 → flag stays 1, winner stays 2, ignored_cnt=2. Eighteen further presses → ignored_cnt=15.
- Ack and release:
  - Store adr=37, writedata=16'h0000 → flag=0 next cycle, FSM in RELEASE_WAIT.
  - Buttons still held → no new flag.
  - Release all, then press btn3 → flag=1, winner=3, ignored_cnt=0.
- Non-ack and reset: while locked, stores adr=36 data 0 and adr=37 data 16'h0001 → flag stays 1. Assert rst while locked → flag=0 and FSM IDLE next edge.
